// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage MIPS pipeline: load-use stall, redirect squash,
// optional mult/div occupancy hold (define MULDIV_STALL_EN) and saturating perf counters.
module pipe_hazard_ctrl #(
    parameter int MULDIV_CYCLES = 4
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic [5:0]  ID_OP,
    input  logic [5:0]  ID_Funct,
    input  logic [4:0]  ID_rs,
    input  logic [4:0]  ID_rt,
    input  logic        EX_MemRead,
    input  logic [4:0]  EX_Wreg_addr,
    input  logic        EX_redirect,
    output logic        PC_en,
    output logic        IFID_en,
    output logic        IFID_flush,
    output logic        IDEX_flush,
    output logic        md_busy,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_count
);

    logic uses_rt;
    logic load_use;
    logic is_md;
    logic is_hilo;
    logic md_hold;
    logic stall;

    assign uses_rt  = (ID_OP == 6'h00) || (ID_OP == 6'h04) || (ID_OP == 6'h05) || (ID_OP == 6'h2B);
    assign load_use = EX_MemRead && (EX_Wreg_addr != 5'd0) &&
                      ((EX_Wreg_addr == ID_rs) || (uses_rt && (EX_Wreg_addr == ID_rt)));
    assign is_md    = (ID_OP == 6'h00) && (ID_Funct inside {6'h18, 6'h19, 6'h1A, 6'h1B});
    assign is_hilo  = (ID_OP == 6'h00) && (ID_Funct inside {6'h10, 6'h12});
    assign md_hold  = md_busy && (is_md || is_hilo);

    // A redirect squashes the ID instruction, so it never also stalls.
    assign stall    = (load_use || md_hold) && !EX_redirect;

    // While reset is held the pipeline is frozen and both latches load bubbles.
    assign PC_en      = RSTn && !stall;
    assign IFID_en    = RSTn && !stall;
    assign IFID_flush = !RSTn || EX_redirect;
    assign IDEX_flush = !RSTn || EX_redirect || stall;

`ifdef MULDIV_STALL_EN
    typedef enum logic {RUN, MD_BUSY} md_state_t;

    md_state_t  state;
    logic [3:0] md_cnt;

    // Redirects do not abort an in-flight mult/div: it is older than the branch.
    always_ff @(negedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state  <= RUN;
            md_cnt <= 4'd0;
        end else begin
            case (state)
                RUN: begin
                    if (is_md && !stall && !EX_redirect) begin
                        state  <= MD_BUSY;
                        md_cnt <= 4'(MULDIV_CYCLES);
                    end
                end
                MD_BUSY: begin
                    if (md_cnt == 4'd1) begin
                        state  <= RUN;
                        md_cnt <= 4'd0;
                    end else begin
                        md_cnt <= md_cnt - 4'd1;
                    end
                end
                default: begin
                    state  <= RUN;
                    md_cnt <= 4'd0;
                end
            endcase
        end
    end

    assign md_busy = (state == MD_BUSY);
`else
    logic [3:0] unused_md_cycles;
    assign unused_md_cycles = 4'(MULDIV_CYCLES);
    assign md_busy          = 1'b0;
`endif

    always_ff @(negedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            stall_cycles <= 16'd0;
            flush_count  <= 16'd0;
        end else begin
            if (stall && (stall_cycles != 16'hFFFF))
                stall_cycles <= stall_cycles + 16'd1;
            if (EX_redirect && (flush_count != 16'hFFFF))
                flush_count <= flush_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed hazard scenarios plus random traffic
// against a behavioural model (mult/div modelled as a remaining-cycle count under MULDIV_STALL_EN).
module tb_pipe_hazard_ctrl;

    localparam int MDC = 4;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic [5:0]  ID_OP;
    logic [5:0]  ID_Funct;
    logic [4:0]  ID_rs;
    logic [4:0]  ID_rt;
    logic        EX_MemRead;
    logic [4:0]  EX_Wreg_addr;
    logic        EX_redirect;
    logic        PC_en;
    logic        IFID_en;
    logic        IFID_flush;
    logic        IDEX_flush;
    logic        md_busy;
    logic [15:0] stall_cycles;
    logic [15:0] flush_count;

    pipe_hazard_ctrl #(.MULDIV_CYCLES(MDC)) dut (
        .CLK(CLK), .RSTn(RSTn), .ID_OP(ID_OP), .ID_Funct(ID_Funct), .ID_rs(ID_rs), .ID_rt(ID_rt),
        .EX_MemRead(EX_MemRead), .EX_Wreg_addr(EX_Wreg_addr), .EX_redirect(EX_redirect),
        .PC_en(PC_en), .IFID_en(IFID_en), .IFID_flush(IFID_flush), .IDEX_flush(IDEX_flush),
        .md_busy(md_busy), .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 CLK = ~CLK;

    int n_vec  = 0;
    int n_err  = 0;
    int md_left = 0;
    int m_stall = 0;
    int m_flush = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic bit model_stall();
        bit reads_rt, lu, md;
        reads_rt = ID_OP inside {6'h00, 6'h04, 6'h05, 6'h2B};
        lu = EX_MemRead && EX_Wreg_addr != 0 &&
             (EX_Wreg_addr == ID_rs || (reads_rt && EX_Wreg_addr == ID_rt));
`ifdef MULDIV_STALL_EN
        md = md_left > 0 && ID_OP == 0 && ID_Funct inside {6'h18, 6'h19, 6'h1A, 6'h1B, 6'h10, 6'h12};
`else
        md = 1'b0;
`endif
        return (lu || md) && !EX_redirect;
    endfunction

    // Inputs are set before the call; outputs are checked at posedge, model advances at negedge.
    task automatic cycle();
        bit st;
        @(posedge CLK);
        #1;
        st = model_stall();
        check_val("ctl", {27'd0, PC_en, IFID_en, IFID_flush, IDEX_flush, md_busy},
                  {27'd0, !st, !st, EX_redirect, EX_redirect || st, md_left > 0});
        check_val("stall_cycles", {16'd0, stall_cycles}, m_stall);
        check_val("flush_count", {16'd0, flush_count}, m_flush);
        @(negedge CLK);
        if (st && m_stall < 65535) m_stall++;
        if (EX_redirect && m_flush < 65535) m_flush++;
`ifdef MULDIV_STALL_EN
        if (md_left > 0) md_left--;
        else if (ID_OP == 0 && ID_Funct inside {6'h18, 6'h19, 6'h1A, 6'h1B} && !st && !EX_redirect)
            md_left = MDC;
`endif
        #1;
    endtask

    task automatic set_in(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                          input logic [4:0] rt, input logic mr, input logic [4:0] wa, input logic rd);
        ID_OP = op; ID_Funct = fn; ID_rs = rs; ID_rt = rt;
        EX_MemRead = mr; EX_Wreg_addr = wa; EX_redirect = rd;
    endtask

    // Asynchronous reset pulse applied between edges; checks the forced values while low.
    task automatic pulse_reset();
        RSTn = 1'b0;
        #1;
        md_left = 0; m_stall = 0; m_flush = 0;
        check_val("rst_ctl", {27'd0, PC_en, IFID_en, IFID_flush, IDEX_flush, md_busy}, 32'b00110);
        check_val("rst_stall_cycles", {16'd0, stall_cycles}, 0);
        check_val("rst_flush_count", {16'd0, flush_count}, 0);
        #1;
        RSTn = 1'b1;
    endtask

    initial begin
        RSTn = 1'b0;
        set_in(6'h00, 6'h20, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        #12;
        pulse_reset();

        // Load-use on rs: one stall, then the load has moved on.
        set_in(6'h00, 6'h20, 5'd8, 5'd10, 1'b1, 5'd8, 1'b0);
        cycle();
        set_in(6'h00, 6'h20, 5'd8, 5'd10, 1'b0, 5'd9, 1'b0);
        cycle();
        // sw reads rt -> stall; addi does not read rt; $zero never hazards.
        set_in(6'h2B, 6'h00, 5'd3, 5'd8, 1'b1, 5'd8, 1'b0);
        cycle();
        set_in(6'h08, 6'h00, 5'd3, 5'd8, 1'b1, 5'd8, 1'b0);
        cycle();
        set_in(6'h00, 6'h20, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
        cycle();
        // Redirect beats load-use.
        set_in(6'h00, 6'h20, 5'd8, 5'd10, 1'b1, 5'd8, 1'b1);
        cycle();

        // mult advances, then mflo waits for the unit.
        set_in(6'h00, 6'h18, 5'd4, 5'd5, 1'b0, 5'd0, 1'b0);
        cycle();
        set_in(6'h00, 6'h12, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        repeat (MDC + 1) cycle();

        // Reset in the middle of a busy mult/div.
        set_in(6'h00, 6'h1A, 5'd4, 5'd5, 1'b0, 5'd0, 1'b0);
        cycle();
        set_in(6'h00, 6'h10, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        repeat (2) cycle();
        pulse_reset();
        cycle();

        // Random traffic over a small register window to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            logic [5:0] ops[6];
            logic [5:0] fns[8];
            ops = '{6'h00, 6'h04, 6'h05, 6'h2B, 6'h08, 6'h23};
            fns = '{6'h18, 6'h19, 6'h1A, 6'h1B, 6'h10, 6'h12, 6'h20, 6'h21};
            set_in(ops[$urandom_range(0, 5)], fns[$urandom_range(0, 7)],
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                   $urandom_range(0, 4) == 0);
            cycle();
        end

        // Saturation of the stall counter.
        pulse_reset();
        set_in(6'h00, 6'h20, 5'd8, 5'd10, 1'b1, 5'd8, 1'b0);
        repeat (65534 + 3) cycle();
        set_in(6'h00, 6'h20, 5'd8, 5'd10, 1'b0, 5'd8, 1'b0);
        cycle();
        check_val("stall_sat", {16'd0, stall_cycles}, 32'h0000FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
